// File: rtl/color_blob_tracker.sv
// color_blob_tracker: raster-scans the filtered frame RAM, accumulates hit
// statistics (count, bounding box, coordinate sums) and computes the blob
// centroid with two parallel restoring dividers at end of frame.
module color_blob_tracker #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int THRESH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] address_read,
  input  logic [DATA_W-1:0] data_filt_R,
  input  logic [DATA_W-1:0] data_filt_G,
  input  logic [DATA_W-1:0] data_filt_B,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [15:0]       pix_count,
  output logic [7:0]        x_min,
  output logic [7:0]        x_max,
  output logic [7:0]        y_min,
  output logic [7:0]        y_max,
  output logic [7:0]        cx,
  output logic [7:0]        cy
);

  localparam int                N     = IMG_W * IMG_H;
  localparam int                XW    = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] XMASK = ADDR_W'(IMG_W - 1);
  localparam logic [DATA_W-1:0] TH    = DATA_W'(THRESH);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DIV, DONE} state_t;

  state_t      state;
  logic [7:0]  x_d, y_d;
  logic        v_d;
  logic [15:0] acc_cnt;
  logic [23:0] sum_x, sum_y;
  logic [7:0]  bx_min, bx_max, by_min, by_max;
  logic [23:0] qx, qy;
  logic [15:0] rx, ry;
  logic [4:0]  div_cnt;

  logic        hit, acc;
  logic [15:0] cnt_nxt;
  logic [23:0] sx_nxt, sy_nxt;
  logic [16:0] rsx, rsy;
  logic [15:0] rx_n, ry_n;
  logic [23:0] qx_n, qy_n;

  // The sample arriving this cycle belongs to the address issued last cycle
  assign hit = (data_filt_R > TH) || (data_filt_G > TH) || (data_filt_B > TH);
  assign acc = v_d && hit;

  // Next-state accumulator values, so DRAIN can see the final pixel's effect
  always_comb begin
    cnt_nxt = acc_cnt;
    sx_nxt  = sum_x;
    sy_nxt  = sum_y;
    if (acc) begin
      cnt_nxt = acc_cnt + 16'd1;
      sx_nxt  = sum_x + 24'(x_d);
      sy_nxt  = sum_y + 24'(y_d);
    end
  end

  // One restoring-division step per cycle for both axes (divisor = hit count)
  always_comb begin
    rsx = {rx, qx[23]};
    rsy = {ry, qy[23]};
    if (rsx >= {1'b0, acc_cnt}) begin
      rx_n = 16'(rsx - {1'b0, acc_cnt});
      qx_n = {qx[22:0], 1'b1};
    end else begin
      rx_n = rsx[15:0];
      qx_n = {qx[22:0], 1'b0};
    end
    if (rsy >= {1'b0, acc_cnt}) begin
      ry_n = 16'(rsy - {1'b0, acc_cnt});
      qy_n = {qy[22:0], 1'b1};
    end else begin
      ry_n = rsy[15:0];
      qy_n = {qy[22:0], 1'b0};
    end
  end

  // Control FSM, address generator, sample alignment, accumulation and results
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      address_read <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      pix_count    <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      cx           <= '0;
      cy           <= '0;
      x_d          <= '0;
      y_d          <= '0;
      v_d          <= 1'b0;
      acc_cnt      <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      bx_min       <= 8'hFF;
      bx_max       <= '0;
      by_min       <= 8'hFF;
      by_max       <= '0;
      qx           <= '0;
      qy           <= '0;
      rx           <= '0;
      ry           <= '0;
      div_cnt      <= '0;
    end else begin
      done <= 1'b0;
      v_d  <= (state == SCAN);
      x_d  <= 8'(address_read & XMASK);
      y_d  <= 8'(address_read >> XW);

      if (acc) begin
        acc_cnt <= cnt_nxt;
        sum_x   <= sx_nxt;
        sum_y   <= sy_nxt;
        if (acc_cnt == 16'd0) begin
          bx_min <= x_d;
          bx_max <= x_d;
          by_min <= y_d;
          by_max <= y_d;
        end else begin
          if (x_d < bx_min) bx_min <= x_d;
          if (x_d > bx_max) bx_max <= x_d;
          if (y_d < by_min) by_min <= y_d;
          if (y_d > by_max) by_max <= y_d;
        end
      end

      case (state)
        IDLE: if (start) begin
          state        <= SCAN;
          busy         <= 1'b1;
          address_read <= '0;
          acc_cnt      <= '0;
          sum_x        <= '0;
          sum_y        <= '0;
          bx_min       <= 8'hFF;
          bx_max       <= '0;
          by_min       <= 8'hFF;
          by_max       <= '0;
        end
        SCAN: begin
          if (address_read == LAST) begin
            address_read <= '0;
            state        <= DRAIN;
          end else begin
            address_read <= address_read + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_nxt == 16'd0) begin
            // Empty frame: skip the divider and publish an all-zero result
            state     <= DONE;
            done      <= 1'b1;
            found     <= 1'b0;
            pix_count <= '0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            cx        <= '0;
            cy        <= '0;
          end else begin
            state   <= DIV;
            qx      <= sx_nxt;
            qy      <= sy_nxt;
            rx      <= '0;
            ry      <= '0;
            div_cnt <= '0;
          end
        end
        DIV: begin
          qx      <= qx_n;
          qy      <= qy_n;
          rx      <= rx_n;
          ry      <= ry_n;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd23) begin
            // Last quotient bit is resolved this cycle; publish all results together
            state     <= DONE;
            done      <= 1'b1;
            found     <= 1'b1;
            pix_count <= acc_cnt;
            x_min     <= bx_min;
            x_max     <= bx_max;
            y_min     <= by_min;
            y_max     <= by_max;
            cx        <= qx_n[7:0];
            cy        <= qy_n[7:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Bench for color_blob_tracker: two instances (THRESH 0 and 128) scan the
// same frame RAM; a pixel-list reference model predicts their results.
module tb_color_blob_tracker;

  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;

  typedef struct {
    int cnt;
    int xmin, xmax, ymin, ymax;
    int cx, cy;
  } res_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [7:0]  mem_r [0:4095];
  logic [7:0]  mem_g [0:4095];
  logic [7:0]  mem_b [0:4095];
  logic [7:0]  rd_r [2];
  logic [7:0]  rd_g [2];
  logic [7:0]  rd_b [2];
  logic [11:0] addr_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        found_o [2];
  logic [15:0] cnt_o [2];
  logic [7:0]  xmin_o [2];
  logic [7:0]  xmax_o [2];
  logic [7:0]  ymin_o [2];
  logic [7:0]  ymax_o [2];
  logic [7:0]  cx_o [2];
  logic [7:0]  cy_o [2];

  int   checks = 0;
  int   passed = 0;
  res_t prev [2];

  always #5 clk = ~clk;

  // Synchronous-read frame RAM, one read port per instance
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_r[i] <= mem_r[addr_o[i]];
      rd_g[i] <= mem_g[addr_o[i]];
      rd_b[i] <= mem_b[addr_o[i]];
    end
  end

  color_blob_tracker #(.IMG_W(W), .IMG_H(H), .ADDR_W(12), .DATA_W(8), .THRESH(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .address_read(addr_o[0]),
    .data_filt_R(rd_r[0]), .data_filt_G(rd_g[0]), .data_filt_B(rd_b[0]),
    .busy(busy_o[0]), .done(done_o[0]), .found(found_o[0]), .pix_count(cnt_o[0]),
    .x_min(xmin_o[0]), .x_max(xmax_o[0]), .y_min(ymin_o[0]), .y_max(ymax_o[0]),
    .cx(cx_o[0]), .cy(cy_o[0]));

  color_blob_tracker #(.IMG_W(W), .IMG_H(H), .ADDR_W(12), .DATA_W(8), .THRESH(128)) dut1 (
    .clk(clk), .rst(rst), .start(start), .address_read(addr_o[1]),
    .data_filt_R(rd_r[1]), .data_filt_G(rd_g[1]), .data_filt_B(rd_b[1]),
    .busy(busy_o[1]), .done(done_o[1]), .found(found_o[1]), .pix_count(cnt_o[1]),
    .x_min(xmin_o[1]), .x_max(xmax_o[1]), .y_min(ymin_o[1]), .y_max(ymax_o[1]),
    .cx(cx_o[1]), .cy(cy_o[1]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: walk the pixel list, collect hits, then plain integer arithmetic
  function automatic res_t model(input int th);
    res_t r;
    int sx, sy, x, y;
    r = '{cnt: 0, xmin: 1000, xmax: -1, ymin: 1000, ymax: -1, cx: 0, cy: 0};
    sx = 0;
    sy = 0;
    for (int k = 0; k < N; k++) begin
      if (int'(mem_r[k]) > th || int'(mem_g[k]) > th || int'(mem_b[k]) > th) begin
        x = k % W;
        y = k / W;
        r.cnt++;
        sx += x;
        sy += y;
        if (x < r.xmin) r.xmin = x;
        if (x > r.xmax) r.xmax = x;
        if (y < r.ymin) r.ymin = y;
        if (y > r.ymax) r.ymax = y;
      end
    end
    if (r.cnt == 0) r = '{default: 0};
    else begin
      r.cx = sx / r.cnt;
      r.cy = sy / r.cnt;
    end
    return r;
  endfunction

  function automatic res_t get_obs(input int i);
    res_t r;
    r.cnt  = int'(cnt_o[i]);
    r.xmin = int'(xmin_o[i]);
    r.xmax = int'(xmax_o[i]);
    r.ymin = int'(ymin_o[i]);
    r.ymax = int'(ymax_o[i]);
    r.cx   = int'(cx_o[i]);
    r.cy   = int'(cy_o[i]);
    return r;
  endfunction

  function automatic bit same(input res_t a, input res_t b);
    return a.cnt == b.cnt && a.xmin == b.xmin && a.xmax == b.xmax &&
           a.ymin == b.ymin && a.ymax == b.ymax && a.cx == b.cx && a.cy == b.cy;
  endfunction

  task automatic check_res(input string tag, input int i, input res_t e);
    res_t o;
    o = get_obs(i);
    check($sformatf("%s/d%0d/pix_count", tag, i), o.cnt, e.cnt);
    check($sformatf("%s/d%0d/found", tag, i), int'(found_o[i]), (e.cnt != 0) ? 1 : 0);
    check($sformatf("%s/d%0d/x_min", tag, i), o.xmin, e.xmin);
    check($sformatf("%s/d%0d/x_max", tag, i), o.xmax, e.xmax);
    check($sformatf("%s/d%0d/y_min", tag, i), o.ymin, e.ymin);
    check($sformatf("%s/d%0d/y_max", tag, i), o.ymax, e.ymax);
    check($sformatf("%s/d%0d/cx", tag, i), o.cx, e.cx);
    check($sformatf("%s/d%0d/cy", tag, i), o.cy, e.cy);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4096; k++) begin
      mem_r[k] = 8'h00;
      mem_g[k] = 8'h00;
      mem_b[k] = 8'h00;
    end
  endtask

  task automatic set_px(input int x, input int y, input int r, input int g, input int b);
    mem_r[y * W + x] = 8'(r);
    mem_g[y * W + x] = 8'(g);
    mem_b[y * W + x] = 8'(b);
  endtask

  // Start a frame, watch every cycle for address/busy/done timing, then check results
  task automatic run_frame(input string tag);
    res_t e [2];
    int   exp_d [2];
    int   done_at [2];
    int   ndone [2];
    bit   addr_ok [2];
    bit   busy_ok [2];
    bit   hold_ok [2];
    for (int i = 0; i < 2; i++) begin
      e[i]       = model(i == 0 ? 0 : 128);
      exp_d[i]   = (e[i].cnt != 0) ? N + 25 : N + 1;
      done_at[i] = -1;
      ndone[i]   = 0;
      addr_ok[i] = 1'b1;
      busy_ok[i] = 1'b1;
      hold_ok[i] = 1'b1;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c <= N + 30; c++) begin
      // stray start pulses while busy (mid-scan and in DRAIN) must be ignored
      start = (c == 300 || c == N) ? 1'b1 : 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (int'(addr_o[i]) != ((c < N) ? c : 0)) addr_ok[i] = 1'b0;
        if (busy_o[i] !== ((c <= exp_d[i]) ? 1'b1 : 1'b0)) busy_ok[i] = 1'b0;
        if (done_o[i] === 1'b1) begin
          ndone[i]++;
          if (done_at[i] < 0) done_at[i] = c;
        end
        if (c == 600 && !same(get_obs(i), prev[i])) hold_ok[i] = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/d%0d/done_cycle", tag, i), done_at[i], exp_d[i]);
      check($sformatf("%s/d%0d/done_pulses", tag, i), ndone[i], 1);
      check($sformatf("%s/d%0d/addr_seq", tag, i), int'(addr_ok[i]), 1);
      check($sformatf("%s/d%0d/busy_window", tag, i), int'(busy_ok[i]), 1);
      check($sformatf("%s/d%0d/prev_hold", tag, i), int'(hold_ok[i]), 1);
      check_res(tag, i, e[i]);
      prev[i] = e[i];
    end
  endtask

  task automatic fill_random(input int density);
    clear_mem();
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 99) < density) begin
        mem_r[k] = 8'($urandom);
        mem_g[k] = 8'($urandom);
        mem_b[k] = 8'($urandom);
      end
    end
  endtask

  initial begin
    res_t zero;
    bit   no_done;
    zero  = '{default: 0};
    rst   = 1'b1;
    start = 1'b0;
    clear_mem();
    for (int i = 0; i < 2; i++) prev[i] = zero;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset/d%0d/addr", i), int'(addr_o[i]), 0);
      check($sformatf("reset/d%0d/busy", i), int'(busy_o[i]), 0);
      check($sformatf("reset/d%0d/done", i), int'(done_o[i]), 0);
      check_res("reset", i, zero);
    end
    rst = 1'b0;
    @(negedge clk);

    // all-zero frame
    run_frame("zero");

    // single hit at (4,3): only the THRESH=0 instance sees it
    clear_mem();
    set_px(4, 3, 8'h40, 0, 0);
    run_frame("single");

    // rectangle x 10..13, y 20..21 with G above both thresholds
    clear_mem();
    for (int y = 20; y <= 21; y++)
      for (int x = 10; x <= 13; x++)
        set_px(x, y, $urandom_range(0, 128), 8'h81, $urandom_range(0, 128));
    run_frame("rect");

    // full frame
    for (int k = 0; k < N; k++) begin
      mem_r[k] = 8'hFF;
      mem_g[k] = 8'hFF;
      mem_b[k] = 8'hFF;
    end
    run_frame("full");

    // threshold boundary: 0x80 is not a hit at THRESH 128, 0x81 is
    clear_mem();
    set_px(9, 9, 8'h80, 8'h80, 8'h80);
    set_px(20, 30, 8'h80, 8'h80, 8'h80);
    set_px(0, 7, 0, 0, 8'h81);
    set_px(1, 7, 0, 8'h81, 0);
    set_px(5, 7, 8'h81, 0, 0);
    run_frame("thresh");

    // random sparse frames
    fill_random(10);
    run_frame("rand_a");
    fill_random(3);
    run_frame("rand_b");

    // reset at cycle 500 of a scan aborts with all outputs cleared
    fill_random(20);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort/d%0d/addr", i), int'(addr_o[i]), 0);
      check($sformatf("abort/d%0d/busy", i), int'(busy_o[i]), 0);
      check($sformatf("abort/d%0d/done", i), int'(done_o[i]), 0);
      check_res("abort", i, zero);
      prev[i] = zero;
    end
    rst     = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < N + 40; c++) begin
      @(negedge clk);
      if (done_o[0] === 1'b1 || done_o[1] === 1'b1) no_done = 1'b0;
    end
    check("abort/no_done", int'(no_done), 1);

    // a complete scan after the abort
    fill_random(15);
    run_frame("after_abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
